// File: rtl/keypad_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : keypad_uart_tx
// Description : Captures one ASCII character per keypad press into a small
//               circular FIFO and serialises it as asynchronous UART, LSB
//               first, on a registered tx line (8N1 by default).
// Options     : KEYPAD_UART_PARITY_EN - adds an even-parity bit (8E1 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int c_DIV = CLK_HZ / BAUD;
  localparam int c_BW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_AW  = $clog2(FIFO_DEPTH);
  localparam int c_CW  = c_AW + 1;
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(c_DIV - 1);
  localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef KEYPAD_UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // Press detect / FIFO state
  logic            r_start_q;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr;
  logic [c_AW-1:0] r_rd;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;

  // Serialiser state
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_BW-1:0] r_baud;
  logic [c_BW-1:0] w_baud_nxt;
  logic [2:0]      r_bit;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_tx;
  logic            w_tx_nxt;
`ifdef KEYPAD_UART_PARITY_EN
  logic            r_par;
  logic            w_par_nxt;
`endif

  logic w_press;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_baud_end;

  assign w_press    = start & ~r_start_q & (data != 8'h00);
  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  // A same-cycle pop frees a slot, so a press into a full FIFO still lands.
  assign w_push     = w_press & (~w_full | w_pop);
  assign w_baud_end = (r_baud == c_BAUD_LAST);

  assign tx       = r_tx;
  assign overflow = r_ovf;
  assign busy     = (r_state != S_IDLE) | ~w_empty;

  // FIFO storage write port (no reset needed: contents are qualified by count)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= data;
    end
  end

  // Edge-detect register, FIFO pointers/count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_start_q <= start;
      if (w_push) begin
        r_wr <= r_wr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_press && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Serialiser state register; tx is registered so the line is glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef KEYPAD_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef KEYPAD_UART_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Next-state, baud/bit sequencing, FIFO pop and next tx level
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
`ifdef KEYPAD_UART_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd];
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
`ifdef KEYPAD_UART_PARITY_EN
          w_par_nxt   = ^r_mem[r_rd];
`endif
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + c_BW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
`ifdef KEYPAD_UART_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + c_BW'(1);
        end
      end
`ifdef KEYPAD_UART_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + c_BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + c_BW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
      end
    endcase

    // tx for the coming cycle follows the state being entered
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef KEYPAD_UART_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/keypad_uart_tx.md
Name: keypad_uart_tx

Overview:
- Downstream consumer of the keypad decoder's `data[7:0]` (ASCII) and `start` (level, high while a key is held).
- Captures one character per key press into a small FIFO and serialises it as asynchronous UART, 8N1, LSB first, on a single `tx` line toward the host.
- Isolates key-press timing from baud timing, so fast repeated presses are buffered rather than lost.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate; bit period DIV = CLK_HZ/BAUD clocks (integer division, DIV >= 2 required).
- FIFO_DEPTH, 4, character buffer depth; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  8  ASCII character from the decoder; 8'h00 means no key.
- start  input  1  decoder key-valid level.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.
- overflow  output  1  sticky; set when a press is dropped because the FIFO is full.

Behaviour:
- Reset (sampled at a clk edge while `reset`=1):
  - tx=1, busy=0, overflow=0.
  - FIFO emptied, FSM to IDLE, baud counter=0, start_q=0.
  - Reset mid-frame aborts the frame; tx returns high on that edge.
- Press detect:
  - start_q is a registered copy of `start`.
  - press = start & ~start_q & (data != 8'h00).
  - Holding a key produces exactly one press; releasing it produces none.
- Enqueue: on the edge where press=1, `data` is written to the FIFO if not full.
  - If full, the character is dropped, overflow is set to 1, and overflow stays set until reset.
- FIFO:
  - Circular buffer with wrapping read and write pointers, plus a count of width clog2(FIFO_DEPTH)+1.
  - Simultaneous enqueue and dequeue in one cycle is legal; count is unchanged.
  - Enqueue when full and dequeue in the same cycle: the dequeue frees space, so the enqueue succeeds and no overflow is flagged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty, pop the head into an 8-bit shift register, clear the baud counter and the bit index, and go to START.
  - START: tx=0 for DIV clocks, then go to DATA.
  - DATA: tx=shift[0] for DIV clocks per bit, shifting right after each bit. After bit index 7 completes (8 bits), go to STOP.
  - STOP: tx=1 for DIV clocks, then go to IDLE.
  - Back-to-back: a non-empty FIFO in IDLE starts the next frame on the following edge, so there is exactly 1 idle clock between frames.
- Baud counter: counts 0..DIV-1 and wraps to 0 at the end of each bit.
- Latency:
  - Press sampled at edge k → FIFO written at edge k.
  - FSM leaves IDLE at edge k+1; tx falls at edge k+1.
  - The frame lasts 10*DIV clocks.
- tx is driven from a register, so it is glitch-free.
- busy is combinational from FSM state and FIFO count.

Optional Feature:
- Macro: KEYPAD_UART_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for DIV clocks.
  - Frame becomes 11*DIV clocks (8E1).
- Undefined: there is no PARITY state and the frame is 8N1 only.
- Press detect, FIFO and overflow behaviour are identical in both builds.

Test Plan (CLK_HZ=1000, BAUD=100, so DIV=10; FIFO_DEPTH=4):
- Reset, then idle 50 clks → tx=1, busy=0, overflow=0 throughout.
- Single press, data=8'h35, start high for 200 clks, then low → exactly one frame:
  - tx: 10 clks low, then bits 1,0,1,0,1,1,0,0 at 10 clks each, then 10 clks high.
  - busy falls 100 clks after tx fell.
- Hold and repeat-edge rejection: start held high 500 clks with data=8'h31 → only one frame; a press with data=8'h00 → no frame.
- Burst of 6 presses ('1'..'6') spaced 3 clks apart during the first frame:
  - Frames '1','2','3','4','5' are sent; '6' is dropped and overflow=1.
  - Frames are separated by 1 idle clk.
- Reset asserted at clk 45 of a frame → tx=1 on that edge, FIFO empty, no further frame, overflow=0.
- With KEYPAD_UART_PARITY_EN defined:
  - data=8'h37 → parity bit 1, frame 110 clks.
  - data=8'h30 → parity bit 0.
